// File: rtl/ex_stage_pkg.sv
// Shared constants and types for the ID/EX operand stage feeding the 64-bit ALU.
// ALU select codes, aluop encoding, R-type opcodes and the zero-register index live here.
package ex_stage_pkg;

  localparam int XLEN   = 64;
  localparam int REG_AW = 5;

  localparam logic [REG_AW-1:0] XZR_IDX = REG_AW'((1 << REG_AW) - 1);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam logic [10:0] OPC_ADD = 11'b10001011000;
  localparam logic [10:0] OPC_SUB = 11'b11001011000;
  localparam logic [10:0] OPC_AND = 11'b10001010000;
  localparam logic [10:0] OPC_ORR = 11'b10101010000;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_RSVD  = 2'b11
  } aluop_e;

  typedef struct packed {
    logic [3:0]        select;
    logic [XLEN-1:0]   input1;
    logic [XLEN-1:0]   input2;
    logic [REG_AW-1:0] rd_idx;
    logic              illegal;
  } ex_op_t;

endpackage

// File: rtl/ex_operand_stage_if.sv
// Decode-to-ALU bus of the operand stage: incoming decoded op, bypass sources, outgoing ALU op.
// master = upstream/downstream environment, slave = the operand stage itself.
interface ex_operand_stage_if
  import ex_stage_pkg::*;
();

  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_aluop;
  logic [10:0]       in_opcode;
  logic              in_alusrc;
  logic [REG_AW-1:0] in_rn_idx;
  logic [XLEN-1:0]   in_rn_val;
  logic [REG_AW-1:0] in_rm_idx;
  logic [XLEN-1:0]   in_rm_val;
  logic [XLEN-1:0]   in_imm;
  logic [REG_AW-1:0] in_rd_idx;

  logic              exm_wr_en;
  logic [REG_AW-1:0] exm_rd_idx;
  logic [XLEN-1:0]   exm_result;
  logic              mwb_wr_en;
  logic [REG_AW-1:0] mwb_rd_idx;
  logic [XLEN-1:0]   mwb_result;

  logic              out_valid;
  logic              out_ready;
  logic [3:0]        out_select;
  logic [XLEN-1:0]   out_input1;
  logic [XLEN-1:0]   out_input2;
  logic [REG_AW-1:0] out_rd_idx;
  logic              out_illegal;

  modport slave (
    input  in_valid, in_aluop, in_opcode, in_alusrc, in_rn_idx, in_rn_val,
           in_rm_idx, in_rm_val, in_imm, in_rd_idx,
           exm_wr_en, exm_rd_idx, exm_result, mwb_wr_en, mwb_rd_idx, mwb_result,
           out_ready,
    output in_ready, out_valid, out_select, out_input1, out_input2, out_rd_idx, out_illegal
  );

  modport master (
    output in_valid, in_aluop, in_opcode, in_alusrc, in_rn_idx, in_rn_val,
           in_rm_idx, in_rm_val, in_imm, in_rd_idx,
           exm_wr_en, exm_rd_idx, exm_result, mwb_wr_en, mwb_rd_idx, mwb_result,
           out_ready,
    input  in_ready, out_valid, out_select, out_input1, out_input2, out_rd_idx, out_illegal
  );

endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU control: maps aluop and R-type opcode to the 4-bit ALU select.
// Unsupported encodings fall back to ADD and raise illegal.
module alu_ctrl_decode
  import ex_stage_pkg::*;
(
  input  aluop_e      aluop_i,
  input  logic [10:0] opcode_i,
  output logic [3:0]  select_o,
  output logic        illegal_o
);

  always_comb begin
    // NOTE: defaults first so every path assigns every output -- no latch is inferred.
    select_o  = ALU_ADD;
    illegal_o = 1'b0;
    case (aluop_i)
      ALUOP_ADD: select_o = ALU_ADD;
      ALUOP_SUB: select_o = ALU_SUB;
      ALUOP_RTYPE: begin
        case (opcode_i)
          OPC_ADD: select_o = ALU_ADD;
          OPC_SUB: select_o = ALU_SUB;
          OPC_AND: select_o = ALU_AND;
          OPC_ORR: select_o = ALU_OR;
          default: illegal_o = 1'b1;
        endcase
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX operand stage: decodes ALU select, selects and forwards operands, registers them for the ALU.
// Build option EX_FWD_EN enables the EX/MEM and MEM/WB bypass network; otherwise operands come from the register file.
module ex_operand_stage
  import ex_stage_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  input logic              flush,
  ex_operand_stage_if.slave bus
);

  logic       out_valid_q, out_valid_d;
  ex_op_t     op_q, op_d;
  logic       in_ready;
  logic       capture;
  logic [3:0] dec_select;
  logic       dec_illegal;
  logic [XLEN-1:0] opa, opb;

  assign in_ready = !out_valid_q || bus.out_ready;
  assign capture  = bus.in_valid && in_ready;

  alu_ctrl_decode u_alu_ctrl_decode (
    .aluop_i   (aluop_e'(bus.in_aluop)),
    .opcode_i  (bus.in_opcode),
    .select_o  (dec_select),
    .illegal_o (dec_illegal)
  );

`ifdef EX_FWD_EN
  // The zero register never matches a producer, and the younger EX/MEM result beats MEM/WB.
  function automatic logic [XLEN-1:0] fwd(
    input logic [REG_AW-1:0] idx,
    input logic [XLEN-1:0]   rf_val,
    input logic              exm_we,
    input logic [REG_AW-1:0] exm_idx,
    input logic [XLEN-1:0]   exm_val,
    input logic              mwb_we,
    input logic [REG_AW-1:0] mwb_idx,
    input logic [XLEN-1:0]   mwb_val
  );
    if (idx == XZR_IDX)                 return rf_val;
    else if (exm_we && exm_idx == idx)  return exm_val;
    else if (mwb_we && mwb_idx == idx)  return mwb_val;
    else                                return rf_val;
  endfunction

  assign opa = fwd(bus.in_rn_idx, bus.in_rn_val, bus.exm_wr_en, bus.exm_rd_idx, bus.exm_result,
                   bus.mwb_wr_en, bus.mwb_rd_idx, bus.mwb_result);
  assign opb = fwd(bus.in_rm_idx, bus.in_rm_val, bus.exm_wr_en, bus.exm_rd_idx, bus.exm_result,
                   bus.mwb_wr_en, bus.mwb_rd_idx, bus.mwb_result);
`else
  logic unused_fwd;
  assign unused_fwd = ^{bus.exm_wr_en, bus.exm_rd_idx, bus.exm_result,
                        bus.mwb_wr_en, bus.mwb_rd_idx, bus.mwb_result};
  assign opa = bus.in_rn_val;
  assign opb = bus.in_rm_val;
`endif

  always_comb begin
    op_d.select  = dec_select;
    op_d.input1  = opa;
    op_d.input2  = bus.in_alusrc ? bus.in_imm : opb;
    op_d.rd_idx  = bus.in_rd_idx;
    op_d.illegal = dec_illegal;
  end

  always_comb begin
    if (flush)          out_valid_d = 1'b0;
    else if (capture)   out_valid_d = 1'b1;
    else if (bus.out_ready) out_valid_d = 1'b0;
    else                out_valid_d = out_valid_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      // NOTE: the payload is reset too, because its reset value (select=ADD, zeros) is visible on the ports.
      op_q        <= '{select: ALU_ADD, default: '0};
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      out_valid_q <= out_valid_d;
      if (capture) op_q <= op_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_select  = op_q.select;
  assign bus.out_input1  = op_q.input1;
  assign bus.out_input2  = op_q.input2;
  assign bus.out_rd_idx  = op_q.rd_idx;
  assign bus.out_illegal = op_q.illegal;

endmodule
